// File: rtl/lfm_pkg.sv
// Shared types and default widths for the LFM chirp burst sequencer.
package lfm_pkg;

  localparam int LFM_N_PHASE = 32;
  localparam int LFM_CNT_W   = 20;
  localparam int LFM_NCH_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHIRP = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } lfm_state_e;

endpackage

// File: rtl/lfm_chirp_sequencer_if.sv
// Control-side config/command bus and DDS-side outputs of the chirp sequencer.
interface lfm_chirp_sequencer_if
  import lfm_pkg::*;
#(
  parameter int N_PHASE = LFM_N_PHASE,
  parameter int CNT_W   = LFM_CNT_W,
  parameter int NCH_W   = LFM_NCH_W
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [N_PHASE-1:0] cfg_ftw0;
  logic [N_PHASE-1:0] cfg_dftw;
  logic [CNT_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_gap;
  logic [NCH_W-1:0]   cfg_nchirp;
  logic               start;
  logic               abort;
  logic               dds_rst_n;
  logic               dds_load;
  logic [N_PHASE-1:0] dds_ftw;
  logic [N_PHASE-1:0] dds_dftw;
  logic               tx_gate;
  logic [NCH_W-1:0]   chirp_idx;
  logic               busy;
  logic               done;
  logic               aborted;
  logic               cfg_err;

  modport master (
    output cfg_valid, cfg_ftw0, cfg_dftw, cfg_len, cfg_gap, cfg_nchirp, start, abort,
    input  cfg_ready, dds_rst_n, dds_load, dds_ftw, dds_dftw, tx_gate, chirp_idx,
           busy, done, aborted, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ftw0, cfg_dftw, cfg_len, cfg_gap, cfg_nchirp, start, abort,
    output cfg_ready, dds_rst_n, dds_load, dds_ftw, dds_dftw, tx_gate, chirp_idx,
           busy, done, aborted, cfg_err
  );
endinterface

// File: rtl/lfm_seg_counter.sv
// Loadable down-counter timing both the chirp and the gap segments.
module lfm_seg_counter #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = load_val_i;
    else if (en_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/lfm_chirp_sequencer.sv
// Burst controller for the LFM DDS: latches a chirp config, then runs N chirps of LEN samples spaced by GAP.
module lfm_chirp_sequencer
  import lfm_pkg::*;
#(
  parameter int N_PHASE = LFM_N_PHASE,
  parameter int CNT_W   = LFM_CNT_W,
  parameter int NCH_W   = LFM_NCH_W
) (
  input  logic clk,
  input  logic rst_n,
  lfm_chirp_sequencer_if.slave bus
);
  lfm_state_e         state_q, state_d;
  logic [N_PHASE-1:0] ftw0_q, dftw_q, eff_ftw0, eff_dftw;
  logic [CNT_W-1:0]   len_q, gap_q, eff_len;
  logic [NCH_W-1:0]   nch_q, eff_nch, nch_last;
  logic [NCH_W-1:0]   idx_q, idx_d;
  logic [N_PHASE-1:0] dds_ftw_q, dds_dftw_q;
  logic               cfg_we, err_d, aborted_d;
  logic               load_q, chirp_q, busy_q, done_q, aborted_q, cfg_err_q;
  logic               cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0]   cnt_val;

  // A write in the same cycle as start must take effect for that burst.
  assign cfg_we   = (state_q == ST_IDLE) && bus.cfg_valid;
  assign eff_ftw0 = cfg_we ? bus.cfg_ftw0   : ftw0_q;
  assign eff_dftw = cfg_we ? bus.cfg_dftw   : dftw_q;
  assign eff_len  = cfg_we ? bus.cfg_len    : len_q;
  assign eff_nch  = cfg_we ? bus.cfg_nchirp : nch_q;
  assign nch_last = nch_q - NCH_W'(1);

  lfm_seg_counter #(.CNT_W(CNT_W)) u_seg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .load_val_i(cnt_val),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_val   = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          if (eff_len == '0 || eff_nch == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = '0;
          end
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        cnt_val  = len_q - CNT_W'(1);
        state_d  = ST_CHIRP;
      end
      ST_CHIRP: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (idx_q == nch_last) begin
          state_d = ST_DONE;
        end else if (gap_q == '0) begin
          state_d = ST_LOAD;
          idx_d   = idx_q + NCH_W'(1);
        end else begin
          state_d  = ST_GAP;
          cnt_load = 1'b1;
          cnt_val  = gap_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else begin
          state_d = ST_LOAD;
          idx_d   = idx_q + NCH_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      idx_d     = idx_q;
      aborted_d = 1'b1;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw0_q <= '0;
      dftw_q <= '0;
      len_q  <= '0;
      gap_q  <= '0;
      nch_q  <= '0;
    end else if (cfg_we) begin
      ftw0_q <= bus.cfg_ftw0;
      dftw_q <= bus.cfg_dftw;
      len_q  <= bus.cfg_len;
      gap_q  <= bus.cfg_gap;
      nch_q  <= bus.cfg_nchirp;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      load_q     <= 1'b0;
      chirp_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      dds_ftw_q  <= '0;
      dds_dftw_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      load_q    <= (state_d == ST_LOAD);
      chirp_q   <= (state_d == ST_CHIRP);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      aborted_q <= aborted_d;
      cfg_err_q <= err_d;
      if (state_d == ST_LOAD) begin
        dds_ftw_q  <= eff_ftw0;
        dds_dftw_q <= eff_dftw;
      end
    end
  end

  assign bus.cfg_ready = (state_q == ST_IDLE);
  assign bus.dds_rst_n = chirp_q;
  assign bus.tx_gate   = chirp_q;
  assign bus.dds_load  = load_q;
  assign bus.dds_ftw   = dds_ftw_q;
  assign bus.dds_dftw  = dds_dftw_q;
  assign bus.chirp_idx = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_lfm_chirp_sequencer.sv
// Bench for lfm_chirp_sequencer: burst-schedule model checked every cycle plus directed literal checks.
module tb_lfm_chirp_sequencer;
  import lfm_pkg::*;
  localparam int NP = 32;
  localparam int CW = 20;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  lfm_chirp_sequencer_if #(.N_PHASE(NP), .CNT_W(CW), .NCH_W(NW)) bus ();
  lfm_chirp_sequencer #(.N_PHASE(NP), .CNT_W(CW), .NCH_W(NW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Burst model: a burst started in cycle m_ts is a fixed schedule of offsets from m_ts.
  bit          m_active = 1'b0;
  int          m_ts = 0, m_L = 1, m_G = 0, m_N = 1, m_ta = -1, m_err = -100, m_pidx = 0;
  logic [31:0] m_bftw = '0, m_bdftw = '0, m_pftw = '0, m_pdftw = '0;
  logic [31:0] s_ftw = '0, s_dftw = '0;
  int          s_len = 0, s_gap = 0, s_n = 0;

  function automatic int end_off();
    return (m_N - 1) * (1 + m_L + m_G) + m_L + 2;
  endfunction

  function automatic bit live(int t);
    int o = t - m_ts;
    return m_active && o >= 1 && o <= end_off() && (m_ta < 0 || t <= m_ta);
  endfunction

  function automatic int chirp_of(int t);
    int k = (t - m_ts - 1) / (1 + m_L + m_G);
    return (k > m_N - 1) ? m_N - 1 : k;
  endfunction

  function automatic int phase_of(int t);
    return (t - m_ts - 1) - chirp_of(t) * (1 + m_L + m_G);
  endfunction

  function automatic int idx_at(int t);
    int tl;
    if (!m_active || t - m_ts < 1) return m_pidx;
    tl = (m_ta >= 0) ? m_ta : m_ts + end_off();
    return chirp_of((t < tl) ? t : tl);
  endfunction

  function automatic logic [31:0] ftw_at(int t);
    return (m_active && t - m_ts >= 1) ? m_bftw : m_pftw;
  endfunction

  function automatic logic [31:0] dftw_at(int t);
    return (m_active && t - m_ts >= 1) ? m_bdftw : m_pdftw;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  bit e_live, e_ld, e_gate, e_done;
  always @(negedge clk) begin
    e_live = live(cyc);
    e_ld   = e_live && phase_of(cyc) == 0;
    e_gate = e_live && phase_of(cyc) >= 1 && phase_of(cyc) <= m_L;
    e_done = e_live && (cyc - m_ts) == end_off();
    chk("cfg_ready", 64'(bus.cfg_ready), 64'(!e_live));
    chk("busy",      64'(bus.busy),      64'(e_live));
    chk("dds_load",  64'(bus.dds_load),  64'(e_ld));
    chk("tx_gate",   64'(bus.tx_gate),   64'(e_gate));
    chk("dds_rst_n", 64'(bus.dds_rst_n), 64'(e_gate));
    chk("done",      64'(bus.done),      64'(e_done));
    chk("aborted",   64'(bus.aborted),   64'(m_active && m_ta >= 0 && cyc == m_ta + 1));
    chk("cfg_err",   64'(bus.cfg_err),   64'(cyc == m_err));
    chk("chirp_idx", 64'(bus.chirp_idx), 64'(idx_at(cyc)));
    chk("dds_ftw",   64'(bus.dds_ftw),   64'(ftw_at(cyc)));
    chk("dds_dftw",  64'(bus.dds_dftw),  64'(dftw_at(cyc)));
  end

  task automatic set_cfg(input logic [31:0] f, input logic [31:0] d, input int len, input int gap, input int n);
    bus.cfg_ftw0   = f;
    bus.cfg_dftw   = d;
    bus.cfg_len    = CW'(len);
    bus.cfg_gap    = CW'(gap);
    bus.cfg_nchirp = NW'(n);
  endtask

  // Applies one cycle of control inputs (called just after a rising edge) and advances the model.
  task automatic drive(input bit cv, input bit st, input bit ab);
    int c = cyc;
    bit idle = !live(c);
    bus.cfg_valid = cv;
    bus.start     = st;
    bus.abort     = ab;
    if (idle && cv) begin
      s_ftw = bus.cfg_ftw0; s_dftw = bus.cfg_dftw;
      s_len = int'(bus.cfg_len); s_gap = int'(bus.cfg_gap); s_n = int'(bus.cfg_nchirp);
    end
    if (idle && st && !ab) begin
      if (s_len == 0 || s_n == 0) begin
        m_err = c + 1;
      end else begin
        m_pftw = ftw_at(c); m_pdftw = dftw_at(c); m_pidx = idx_at(c);
        m_active = 1'b1; m_ts = c; m_ta = -1;
        m_L = s_len; m_G = s_gap; m_N = s_n; m_bftw = s_ftw; m_bdftw = s_dftw;
      end
    end
    if (ab && !idle) m_ta = c;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  task automatic at_neg(input int t);
    wait_cyc(t);
    @(negedge clk);
  endtask

  int ts, ts2, loads, dones;
  logic [5:0] pat;

  initial begin
    bus.cfg_valid = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    set_cfg(32'h0, 32'h0, 0, 0, 0);
    @(negedge clk);
    chk("reset cfg_ready", 64'(bus.cfg_ready), 64'd1);
    chk("reset dds_rst_n", 64'(bus.dds_rst_n), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zeroed config after reset is refused.
    ts = cyc; drive(0, 1, 0);
    at_neg(ts + 1);
    chk("t0 cfg_err", 64'(bus.cfg_err), 64'd1);
    wait_cyc(ts + 3);

    // Basic burst len=4 gap=2 n=2.
    set_cfg(32'h1000_0000, 32'h0000_0100, 4, 2, 2);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    at_neg(ts + 1);  chk("t1 load1", 64'(bus.dds_load), 64'd1);
    at_neg(ts + 2);  chk("t1 gate first", 64'(bus.tx_gate), 64'd1);
    at_neg(ts + 5);  chk("t1 gate last", 64'(bus.tx_gate), 64'd1);
    at_neg(ts + 6);  chk("t1 gap", 64'(bus.tx_gate), 64'd0);
    at_neg(ts + 8);  chk("t1 load2", 64'(bus.dds_load), 64'd1);
    at_neg(ts + 13); chk("t1 done", 64'(bus.done), 64'd1);
    at_neg(ts + 14); chk("t1 busy off", 64'(bus.busy), 64'd0);
    wait_cyc(ts + 17);

    // Back-to-back single-sample chirps.
    set_cfg(32'h0200_0000, 32'h0000_0001, 1, 0, 3);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    pat = '0; loads = 0; dones = 0;
    for (int o = 1; o <= 10; o++) begin
      at_neg(ts + o);
      if (o <= 6) pat = {pat[4:0], bus.tx_gate};
      loads += int'(bus.dds_load);
      dones += int'(bus.done);
      if (o == 5) chk("t2 idx2", 64'(bus.chirp_idx), 64'd2);
    end
    chk("t2 gate pattern", 64'(pat), 64'(6'b010101));
    chk("t2 loads", 64'(loads), 64'd3);
    chk("t2 dones", 64'(dones), 64'd1);

    // Abort at the third gate cycle of chirp 1, then restart.
    set_cfg(32'h0300_0000, 32'h0000_0002, 8, 3, 4);
    wait_cyc(cyc + 1);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    wait_cyc(ts + 16);
    chk("t3 idx before abort", 64'(bus.chirp_idx), 64'd1);
    drive(0, 0, 1);
    chk("t3 aborted", 64'(bus.aborted), 64'd1);
    chk("t3 busy", 64'(bus.busy), 64'd0);
    chk("t3 gate", 64'(bus.tx_gate), 64'd0);
    wait_cyc(cyc + 2);
    ts2 = cyc; drive(0, 1, 0);
    at_neg(ts2 + 1);
    chk("t3 restart idx", 64'(bus.chirp_idx), 64'd0);
    chk("t3 restart load", 64'(bus.dds_load), 64'd1);
    wait_cyc(ts2 + 50);

    // Invalid config: len=0, then nchirp=0 written in the start cycle.
    set_cfg(32'h0400_0000, 32'h0, 0, 1, 2);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    at_neg(ts + 1);
    chk("t4 err len", 64'(bus.cfg_err), 64'd1);
    chk("t4 no load", 64'(bus.dds_load), 64'd0);
    wait_cyc(ts + 3);
    set_cfg(32'h0400_0000, 32'h0, 5, 1, 0);
    ts = cyc; drive(1, 1, 0);
    at_neg(ts + 1);
    chk("t4 err nchirp", 64'(bus.cfg_err), 64'd1);
    chk("t4 busy", 64'(bus.busy), 64'd0);
    wait_cyc(ts + 3);

    // Config write and start during a burst are ignored; idle abort (with start) too.
    set_cfg(32'h1234_5678, 32'h0000_0040, 6, 2, 2);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    wait_cyc(ts + 4);
    set_cfg(32'h0100_0000, 32'h0000_0080, 3, 0, 1);
    drive(1, 1, 0);
    chk("t5 cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("t5 ftw held", 64'(bus.dds_ftw), 64'h1234_5678);
    wait_cyc(ts + 20);
    drive(0, 1, 1);
    chk("t5 idle abort+start", 64'(bus.busy), 64'd0);
    ts2 = cyc; drive(0, 1, 0);
    at_neg(ts2 + 1);
    chk("t5 frozen ftw", 64'(bus.dds_ftw), 64'h1234_5678);
    wait_cyc(ts2 + 20);

    // Async reset mid-chirp, then start with a down-chirp config written the same cycle.
    set_cfg(32'h2000_0000, 32'h0000_0200, 10, 1, 3);
    drive(1, 0, 0);
    ts = cyc; drive(0, 1, 0);
    wait_cyc(ts + 4);
    #2 rst_n = 1'b0;
    m_active = 1'b0; m_ta = -1; m_err = -100; m_pidx = 0;
    m_pftw = '0; m_pdftw = '0; s_ftw = '0; s_dftw = '0; s_len = 0; s_gap = 0; s_n = 0;
    #1;
    chk("t6 rst gate", 64'(bus.tx_gate), 64'd0);
    chk("t6 rst dds_rst_n", 64'(bus.dds_rst_n), 64'd0);
    chk("t6 rst busy", 64'(bus.busy), 64'd0);
    chk("t6 rst ftw", 64'(bus.dds_ftw), 64'd0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    set_cfg(32'h0800_0000, 32'hFFFF_FF00, 3, 0, 2);
    ts = cyc; drive(1, 1, 0);
    at_neg(ts + 1);
    chk("t6 dftw", 64'(bus.dds_dftw), 64'hFFFF_FF00);
    chk("t6 ftw", 64'(bus.dds_ftw), 64'h0800_0000);
    wait_cyc(ts + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
